// File: rtl/play_capture_pkg.sv
// ----------------------------------------------------------------------------
// play_capture_pkg
//   Shared constants and types for the play-capture block.
//   NUM_PLAYERS : number of players feeding the comparator
//   PLAY_W      : width of one player's play
//   state_t     : capture FSM states (COLLECT while plays arrive, READY while
//                 the locked plays are presented to the comparator)
// ----------------------------------------------------------------------------
package play_capture_pkg;

    localparam int unsigned NUM_PLAYERS = 4;
    localparam int unsigned PLAY_W      = 3;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        READY   = 1'b1
    } state_t;

endpackage

// File: rtl/play_capture_round_timer.sv
// ----------------------------------------------------------------------------
// round_timer
//   Cycle timer that bounds how long a round may stay open.
//   clk     : clock, rising-edge active
//   rst     : asynchronous active-high reset, clears the count
//   clear   : synchronous clear (round restart)
//   enable  : count one per cycle while high
//   expired : high in the cycle where the count has reached TIMEOUT_CYCLES-1
// ----------------------------------------------------------------------------
module round_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned     CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Count stops at LAST so it never wraps back into a fresh window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != LAST)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expired = enable && (r_count == LAST);

endmodule

// File: rtl/play_capture.sv
// ----------------------------------------------------------------------------
// play_capture
//   Collects one play per player for a round, locks the first play each
//   player submits, and presents the complete set to a downstream comparator.
//   A round closes when all players have entered or the timer expires.
//   clk         : clock, rising-edge active
//   rst         : asynchronous active-high reset
//   enter       : strobe submitting value for player_sel
//   player_sel  : player index (0=J1 .. 3=J4)
//   value       : the submitted play
//   next_round  : strobe releasing a READY round
//   j1..j4      : locked plays
//   entered     : per-player lock flags (bit k = player k+1)
//   round_valid : registered, high while in READY
//   timed_out   : round closed with at least one player missing
//   round_num   : current round index, wraps modulo 2^ROUND_W
// ----------------------------------------------------------------------------
module play_capture
    import play_capture_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned ROUND_W        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enter,
    input  logic [1:0]             player_sel,
    input  logic [PLAY_W-1:0]      value,
    input  logic                   next_round,
    output logic [PLAY_W-1:0]      j1,
    output logic [PLAY_W-1:0]      j2,
    output logic [PLAY_W-1:0]      j3,
    output logic [PLAY_W-1:0]      j4,
    output logic [NUM_PLAYERS-1:0] entered,
    output logic                   round_valid,
    output logic                   timed_out,
    output logic [ROUND_W-1:0]     round_num
);

    state_t                               r_state;
    logic [NUM_PLAYERS-1:0][PLAY_W-1:0]   r_play;
    logic [NUM_PLAYERS-1:0]               r_entered;
    logic                                 r_round_valid;
    logic                                 r_timed_out;
    logic [ROUND_W-1:0]                   r_round_num;

    logic                                 w_accept;
    logic [NUM_PLAYERS-1:0]               w_sel_onehot;
    logic [NUM_PLAYERS-1:0]               w_entered_nxt;
    logic                                 w_all_in;
    logic                                 w_release;
    logic                                 w_timer_en;
    logic                                 w_expired;

    always_comb begin
        w_sel_onehot  = NUM_PLAYERS'(1) << player_sel;
        w_accept      = (r_state == COLLECT) && enter && !r_entered[player_sel];
        w_entered_nxt = r_entered | (w_accept ? w_sel_onehot : '0);
        w_all_in      = &w_entered_nxt;
        w_release     = (r_state == READY) && next_round;
        w_timer_en    = (r_state == COLLECT);
    end

    round_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_round_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_release),
        .enable (w_timer_en),
        .expired(w_expired)
    );

    // Close-of-round decisions use the post-edge entered set, so an enter
    // arriving with timer expiry still counts toward a complete round.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= COLLECT;
            r_play        <= '0;
            r_entered     <= '0;
            r_round_valid <= 1'b0;
            r_timed_out   <= 1'b0;
            r_round_num   <= '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        r_play[player_sel] <= value;
                    end
                    r_entered <= w_entered_nxt;
                    if (w_all_in || w_expired) begin
                        r_state       <= READY;
                        r_round_valid <= 1'b1;
                        r_timed_out   <= !w_all_in;
                    end
                end
                READY: begin
                    if (next_round) begin
                        r_state       <= COLLECT;
                        r_play        <= '0;
                        r_entered     <= '0;
                        r_round_valid <= 1'b0;
                        r_timed_out   <= 1'b0;
                        r_round_num   <= r_round_num + ROUND_W'(1);
                    end
                end
                default: begin
                    r_state <= COLLECT;
                end
            endcase
        end
    end

    assign j1          = r_play[0];
    assign j2          = r_play[1];
    assign j3          = r_play[2];
    assign j4          = r_play[3];
    assign entered     = r_entered;
    assign round_valid = r_round_valid;
    assign timed_out   = r_timed_out;
    assign round_num   = r_round_num;

endmodule

// File: tb/tb_play_capture.sv
// ----------------------------------------------------------------------------
// tb_play_capture
//   Directed, table-driven bench for play_capture with a short timeout.
// ----------------------------------------------------------------------------
module tb_play_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       enter;
    logic [1:0] player_sel;
    logic [2:0] value;
    logic       next_round;
    logic [2:0] j1, j2, j3, j4;
    logic [3:0] entered;
    logic       round_valid;
    logic       timed_out;
    logic [3:0] round_num;

    int n_tests = 0;
    int n_fail  = 0;

    play_capture #(
        .TIMEOUT_CYCLES(16),
        .ROUND_W       (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enter      (enter),
        .player_sel (player_sel),
        .value      (value),
        .next_round (next_round),
        .j1         (j1),
        .j2         (j2),
        .j3         (j3),
        .j4         (j4),
        .entered    (entered),
        .round_valid(round_valid),
        .timed_out  (timed_out),
        .round_num  (round_num)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [1:0]  sel;
        logic [2:0]  val;
        logic        nr;
        logic        rv;
        logic [3:0]  ent;
        logic        to;
        logic [11:0] j;
        logic [3:0]  rn;
    } vec_t;

    vec_t tbl [14];

    function automatic logic [11:0] jp(input logic [2:0] a, b, c, d);
        return {a, b, c, d};
    endfunction

    function automatic vec_t mk(input logic en, input logic [1:0] sel, input logic [2:0] val,
                                input logic nr, input logic rv, input logic [3:0] ent,
                                input logic to, input logic [11:0] j, input logic [3:0] rn);
        vec_t v;
        v.en = en; v.sel = sel; v.val = val; v.nr = nr;
        v.rv = rv; v.ent = ent; v.to = to; v.j = j; v.rn = rn;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic rv, input logic [3:0] ent,
                           input logic to, input logic [11:0] j, input logic [3:0] rn);
        chk({name, ".round_valid"}, 32'(round_valid), 32'(rv));
        chk({name, ".entered"},     32'(entered),     32'(ent));
        chk({name, ".timed_out"},   32'(timed_out),   32'(to));
        chk({name, ".j"},           32'({j1, j2, j3, j4}), 32'(j));
        chk({name, ".round_num"},   32'(round_num),   32'(rn));
    endtask

    task automatic drive(input logic en, input logic [1:0] sel, input logic [2:0] val, input logic nr);
        enter = en; player_sel = sel; value = val; next_round = nr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        drive(1'b0, 2'd0, 3'd0, 1'b0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 2'd0, 3'd0, 1'b0);
        rst = 1'b1;

        // Main table: full round, READY hold, first-play lock, ignored next_round
        tbl[0]  = mk(1, 0, 0, 0,  0, 4'b0001, 0, jp(0,0,0,0), 0);
        tbl[1]  = mk(1, 1, 0, 0,  0, 4'b0011, 0, jp(0,0,0,0), 0);
        tbl[2]  = mk(1, 2, 7, 0,  0, 4'b0111, 0, jp(0,0,7,0), 0);
        tbl[3]  = mk(1, 3, 7, 0,  1, 4'b1111, 0, jp(0,0,7,7), 0);
        tbl[4]  = mk(1, 0, 5, 0,  1, 4'b1111, 0, jp(0,0,7,7), 0);
        tbl[5]  = mk(1, 1, 3, 1,  0, 4'b0000, 0, jp(0,0,0,0), 1);
        tbl[6]  = mk(1, 1, 5, 0,  0, 4'b0010, 0, jp(0,5,0,0), 1);
        tbl[7]  = mk(1, 1, 3, 0,  0, 4'b0010, 0, jp(0,5,0,0), 1);
        tbl[8]  = mk(0, 0, 0, 1,  0, 4'b0010, 0, jp(0,5,0,0), 1);
        tbl[9]  = mk(1, 0, 1, 0,  0, 4'b0011, 0, jp(1,5,0,0), 1);
        tbl[10] = mk(1, 2, 2, 0,  0, 4'b0111, 0, jp(1,5,2,0), 1);
        tbl[11] = mk(0, 0, 0, 0,  0, 4'b0111, 0, jp(1,5,2,0), 1);
        tbl[12] = mk(1, 3, 4, 0,  1, 4'b1111, 0, jp(1,5,2,4), 1);
        tbl[13] = mk(0, 0, 0, 1,  0, 4'b0000, 0, jp(0,0,0,0), 2);

        step();
        step();
        rst = 1'b0;
        chk_all("reset", 0, 4'b0000, 0, jp(0,0,0,0), 0);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].en, tbl[i].sel, tbl[i].val, tbl[i].nr);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].rv, tbl[i].ent, tbl[i].to, tbl[i].j, tbl[i].rn);
        end

        // Timeout: only J1 enters; round closes at the 16th COLLECT edge
        drive(1'b1, 2'd0, 3'd7, 1'b0);
        step();
        for (int i = 0; i < 14; i++) idle_step();
        chk("timeout.pre_rv", 32'(round_valid), 32'd0);
        idle_step();
        chk_all("timeout", 1, 4'b0001, 1, jp(7,0,0,0), 2);
        drive(1'b1, 2'd1, 3'd6, 1'b0);
        step();
        chk_all("timeout.hold", 1, 4'b0001, 1, jp(7,0,0,0), 2);
        drive(1'b0, 2'd0, 3'd0, 1'b1);
        step();
        chk_all("timeout.release", 0, 4'b0000, 0, jp(0,0,0,0), 3);

        // Asynchronous reset mid-round discards partial entries
        drive(1'b1, 2'd0, 3'd1, 1'b0);
        step();
        drive(1'b1, 2'd1, 3'd2, 1'b0);
        step();
        chk("arst.pre_entered", 32'(entered), 32'h3);
        drive(1'b0, 2'd0, 3'd0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("arst.async", 0, 4'b0000, 0, jp(0,0,0,0), 0);
        step();
        rst = 1'b0;
        for (int p = 0; p < 4; p++) begin
            drive(1'b1, 2'(p), 3'(p + 3), 1'b0);
            step();
        end
        chk_all("arst.after", 1, 4'b1111, 0, jp(3,4,5,6), 0);

        // Round counter wrap over 16 releases
        drive(1'b0, 2'd0, 3'd0, 1'b1);
        step();
        chk("wrap.rn1", 32'(round_num), 32'd1);
        chk("wrap.rv_drop1", 32'(round_valid), 32'd0);
        for (int r = 2; r <= 16; r++) begin
            for (int p = 0; p < 4; p++) begin
                drive(1'b1, 2'(p), 3'(p + r), 1'b0);
                step();
            end
            chk($sformatf("wrap.rv%0d", r), 32'(round_valid), 32'd1);
            drive(1'b0, 2'd0, 3'd0, 1'b1);
            step();
            chk($sformatf("wrap.rn%0d", r), 32'(round_num), 32'(r % 16));
            chk($sformatf("wrap.rv_drop%0d", r), 32'(round_valid), 32'd0);
        end

        // Last missing enter lands on the timer-expiry edge
        drive(1'b1, 2'd0, 3'd1, 1'b0);
        step();
        drive(1'b1, 2'd1, 3'd2, 1'b0);
        step();
        drive(1'b1, 2'd2, 3'd3, 1'b0);
        step();
        for (int i = 0; i < 12; i++) idle_step();
        chk_all("coinc.pre", 0, 4'b0111, 0, jp(1,2,3,0), 0);
        drive(1'b1, 2'd3, 3'd6, 1'b0);
        step();
        chk_all("coinc", 1, 4'b1111, 0, jp(1,2,3,6), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/play_capture.md
PLAY_CAPTURE -- requirements
Module: play_capture

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000: number of clock cycles spent in COLLECT before the round is forced closed.
REQ-002 Parameter ROUND_W, default 4: width of the round counter.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 enter  in  1  one-cycle strobe that submits `value` for player `player_sel`.
REQ-006 player_sel  in  2  player index: 0=J1, 1=J2, 2=J3, 3=J4.
REQ-007 value  in  3  the player's 3-bit play.
REQ-008 next_round  in  1  one-cycle strobe that releases the current round.
REQ-009 j1, j2, j3, j4  out  3 each  locked plays; bit 2..0 drive comparator inputs Jk2..Jk0.
REQ-010 entered  out  4  bit k set means player k+1 has locked a play this round.
REQ-011 round_valid  out  1  high while j1..j4 are stable and complete for the comparator.
REQ-012 timed_out  out  1  high if the round closed with at least one player missing.
REQ-013 round_num  out  ROUND_W  index of the current round.

Function
REQ-014 The FSM shall have two states: COLLECT and READY; round_valid shall be 1 only in READY, and it shall be a registered output.
REQ-015 In COLLECT, enter with entered[player_sel]=0 shall load `value` into the selected jk and set entered[player_sel] at the same clock edge.
REQ-016 In COLLECT, enter with entered[player_sel]=1 shall be ignored, so the first play locks.
REQ-017 COLLECT shall go to READY at the edge at which entered becomes 4'b1111, so round_valid rises 1 cycle after the last accepted enter is sampled.
REQ-018 A cycle timer shall clear on entry to COLLECT and increment once per COLLECT cycle.
REQ-019 At timer count TIMEOUT_CYCLES-1, COLLECT shall go to READY, and any player not yet entered shall keep the value 0.
REQ-020 timed_out shall be set on the transition into READY if and only if entered is not 4'b1111 after that edge.
REQ-021 If an enter and timer expiry occur in the same cycle, the enter shall be accepted, with timed_out decided per REQ-020.
REQ-022 In READY, enter shall be ignored and j1..j4, entered, and timed_out shall hold.
REQ-023 In READY, next_round shall move the FSM to COLLECT at the next edge; the same edge shall clear j1..j4, entered, timed_out, and the timer, and shall increment round_num modulo 2^ROUND_W.
REQ-024 next_round in COLLECT shall be ignored.
REQ-025 If next_round and enter occur in the same cycle in READY, only next_round shall act.

Reset
REQ-026 While rst=1, the block shall immediately force: state=COLLECT, j1..j4=0, entered=0, round_valid=0, timed_out=0, round_num=0, timer=0.
REQ-027 rst asserted mid-round shall discard all partial entries with no residual effect.

Structure
REQ-028 A shared package shall hold NUM_PLAYERS=4, PLAY_W=3, and the state enum {COLLECT, READY}.
REQ-029 The timer shall be a sub-module round_timer, with ports clk, rst, clear, enable, and expired.
REQ-030 play_capture shall instantiate round_timer exactly once.

Verification
REQ-031 Sequence: enter J1=0, J2=0, J3=7, J4=7 on consecutive cycles -> one cycle after the 4th enter: round_valid=1, j=(0,0,7,7), entered=1111, timed_out=0.
REQ-032 Sequence: enter J2=5, then J2=3 -> j2 stays 5 and entered[1]=1.
REQ-033 With TIMEOUT_CYCLES=16, enter only J1=7 -> READY after 16 COLLECT cycles with timed_out=1, entered=0001, j1=7, j2..j4=0.
REQ-034 Issue next_round in READY 16 times -> round_num runs 1..15 then wraps to 0, and round_valid drops the cycle after each strobe.
REQ-035 Assert rst asynchronously after 2 entries -> all outputs 0 before the next edge; then 4 entries -> normal READY.
REQ-036 Last missing enter coincides with timer expiry -> value captured, entered=1111, timed_out=0.
